// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory port arbiter: owner encoding,
// legal read-latency range and the response tag carried down the pipeline.
package mem_arb_pkg;

    localparam logic OWN_M0 = 1'b0;
    localparam logic OWN_M1 = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    typedef struct packed {
        logic valid;
        logic owner;
    } rsp_tag_t;

    function automatic logic lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/rsp_tag_pipe.sv
// Fixed-depth shift register of read-response tags; the tail entry marks the
// cycle in which the memory read data belongs to its owner.
module rsp_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_valid,
    input  logic load_owner,
    output logic tail_valid,
    output logic tail_owner
);

    rsp_tag_t stage [DEPTH];

    // Clearing every stage on reset drops all in-flight responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= '{valid: load_valid, owner: load_owner};
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tail_valid = stage[DEPTH-1].valid;
    assign tail_owner = stage[DEPTH-1].owner;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the multicycle core
// (master 0) and the loader/debug port (master 1), with tagged read returns.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [DATA_W-1:0] mem_rdata
);

    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("mem_port_arbiter: DATA_W must be 32");
        end
        if (!lat_legal(RD_LAT)) begin : g_bad_rd_lat
            $error("mem_port_arbiter: RD_LAT must be within 1..4");
        end
    endgenerate

    logic prio;
    logic accept;
    logic tail_valid;
    logic tail_owner;

    // Grants are gated by rst so nothing reaches memory while reset is held.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rst) begin
            m0_gnt = m0_req & (~m1_req | (prio == OWN_M0));
            m1_gnt = m1_req & (~m0_req | (prio == OWN_M1));
        end
    end

    assign accept = m0_gnt | m1_gnt;

    // Priority passes to the loser of every accepted transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio <= OWN_M0;
        end else if (accept) begin
            prio <= m0_gnt ? OWN_M1 : OWN_M0;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_wstrb = m0_wstrb;
        if (m1_gnt) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_wstrb = m1_wstrb;
        end else if (m0_gnt) begin
            mem_we    = m0_we;
        end
    end

    assign mem_en = accept;

    // Only accepted reads enter the pipe; writes retire at the accept edge.
    rsp_tag_pipe #(
        .DEPTH(RD_LAT)
    ) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .load_valid (accept & ~mem_we),
        .load_owner (m1_gnt ? OWN_M1 : OWN_M0),
        .tail_valid (tail_valid),
        .tail_owner (tail_owner)
    );

    assign m0_rvalid = tail_valid & (tail_owner == OWN_M0);
    assign m1_rvalid = tail_valid & (tail_owner == OWN_M1);
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two arbiters (RD_LAT 1 and 3) share one stimulus stream;
// each has its own memory model and expected-response queue.
module tb_mem_port_arbiter;

    typedef struct {
        logic        owner;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;

    logic [1:0]  gnt0_s, gnt1_s, rv0_s, rv1_s, en_s, we_s;
    logic [31:0] rd0_s [2];
    logic [31:0] rd1_s [2];
    logic [31:0] maddr_s [2];
    logic [31:0] mwdata_s [2];
    logic [31:0] mrdata_s [2];
    logic [3:0]  mwstrb_s [2];

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   chk_gnt = 1'b0;
    logic [3:0] exp_bus = 4'b0;
    exp_t q [2][$];

    always @(posedge clk) cyc++;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] mem [64];
        logic [31:0] dpipe [LAT];
        bit init_done = 1'b0;

        mem_port_arbiter #(
            .ADDR_W(32),
            .DATA_W(32),
            .RD_LAT(LAT)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .m0_req    (m0_req),
            .m0_we     (m0_we),
            .m0_addr   (m0_addr),
            .m0_wdata  (m0_wdata),
            .m0_wstrb  (m0_wstrb),
            .m0_gnt    (gnt0_s[g]),
            .m0_rvalid (rv0_s[g]),
            .m0_rdata  (rd0_s[g]),
            .m1_req    (m1_req),
            .m1_we     (m1_we),
            .m1_addr   (m1_addr),
            .m1_wdata  (m1_wdata),
            .m1_wstrb  (m1_wstrb),
            .m1_gnt    (gnt1_s[g]),
            .m1_rvalid (rv1_s[g]),
            .m1_rdata  (rd1_s[g]),
            .mem_en    (en_s[g]),
            .mem_we    (we_s[g]),
            .mem_addr  (maddr_s[g]),
            .mem_wdata (mwdata_s[g]),
            .mem_wstrb (mwstrb_s[g]),
            .mem_rdata (mrdata_s[g])
        );

        // Word at byte address A starts as 0xA500_0000 | A.
        always @(posedge clk) begin
            if (!init_done) begin
                for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | 32'(i * 4);
                init_done <= 1'b1;
            end else if (en_s[g] && we_s[g]) begin
                for (int b = 0; b < 4; b++)
                    if (mwstrb_s[g][b]) mem[maddr_s[g][7:2]][8*b +: 8] <= mwdata_s[g][8*b +: 8];
            end
            dpipe[0] <= (en_s[g] && !we_s[g]) ? mem[maddr_s[g][7:2]] : 32'h0;
            for (int k = 1; k < LAT; k++) dpipe[k] <= dpipe[k-1];
        end

        assign mrdata_s[g] = dpipe[LAT-1];
    end

    task automatic checkOutput(input int g);
        exp_t        e;
        logic [3:0]  act;
        logic [31:0] rd;
        int          lat;
        lat = (g == 0) ? 1 : 3;
        act = {gnt0_s[g], gnt1_s[g], en_s[g], we_s[g]};
        if (chk_gnt) begin
            n_tests++;
            if (act !== exp_bus) begin
                n_fail++;
                $display("[TB] FAIL grant lat%0d cyc %0d: gnt0,gnt1,en,we got %b want %b", lat, cyc, act, exp_bus);
            end
        end
        if (rv0_s[g] || rv1_s[g]) begin
            n_tests++;
            if (q[g].size() == 0) begin
                n_fail++;
                $display("[TB] FAIL unexpected_rvalid lat%0d cyc %0d: rvalid0=%b rvalid1=%b, none expected", lat, cyc, rv0_s[g], rv1_s[g]);
            end else begin
                e  = q[g].pop_front();
                rd = rv1_s[g] ? rd1_s[g] : rd0_s[g];
                if (!(rv0_s[g] ^ rv1_s[g]) || (rv1_s[g] != e.owner) || (rd !== e.data) || (cyc != e.due)) begin
                    n_fail++;
                    $display("[TB] FAIL response lat%0d: got rv0=%b rv1=%b data=%h cyc=%0d, want owner=%0d data=%h cyc=%0d",
                             lat, rv0_s[g], rv1_s[g], rd, cyc, e.owner, e.data, e.due);
                end
            end
        end else if (q[g].size() != 0 && q[g][0].due <= cyc) begin
            n_tests++;
            n_fail++;
            e = q[g].pop_front();
            $display("[TB] FAIL missing_rvalid lat%0d cyc %0d: got no rvalid, want owner=%0d data=%h", lat, cyc, e.owner, e.data);
        end
    endtask

    always @(negedge clk) begin
        checkOutput(0);
        checkOutput(1);
    end

    // Drives one cycle of requests and records the hand-computed outcome.
    task automatic applyStimulus(
        input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] s0,
        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1,
        input logic eg0, input logic eg1, input logic [31:0] ed);
        exp_t e;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0; m0_wstrb = s0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_wstrb = s1;
        exp_bus = {eg0, eg1, eg0 | eg1, (eg0 & w0) | (eg1 & w1)};
        chk_gnt = 1'b1;
        if ((eg0 && !w0) || (eg1 && !w1)) begin
            for (int g = 0; g < 2; g++) begin
                e.owner = eg1;
                e.data  = ed;
                e.due   = cyc + ((g == 0) ? 1 : 3);
                q[g].push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(0, 0, 0, 0, 4'hF, 0, 0, 0, 0, 4'hF, 0, 0, 0);
    endtask

    task automatic assertReset();
        rst = 1'b0;
        q[0].delete();
        q[1].delete();
    endtask

    initial begin
        rst = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        repeat (2) @(posedge clk);
        #1;
        // Requests during reset must not be granted
        applyStimulus(1, 0, 32'h00, 0, 4'hF, 1, 0, 32'h04, 0, 4'hF, 0, 0, 0);
        rst = 1'b1;

        // Master 0 alone, consecutive reads
        applyStimulus(1, 0, 32'h00, 0, 4'hF, 0, 0, 0, 0, 4'hF, 1, 0, 32'hA500_0000);
        applyStimulus(1, 0, 32'h04, 0, 4'hF, 0, 0, 0, 0, 4'hF, 1, 0, 32'hA500_0004);
        applyStimulus(1, 0, 32'h08, 0, 4'hF, 0, 0, 0, 0, 4'hF, 1, 0, 32'hA500_0008);
        idle(4);

        // Continuous contention from reset alternates m0, m1, m0, m1
        assertReset();
        idle(1);
        rst = 1'b1;
        applyStimulus(1, 0, 32'h20, 0, 4'hF, 1, 0, 32'h30, 0, 4'hF, 1, 0, 32'hA500_0020);
        applyStimulus(1, 0, 32'h24, 0, 4'hF, 1, 0, 32'h30, 0, 4'hF, 0, 1, 32'hA500_0030);
        applyStimulus(1, 0, 32'h24, 0, 4'hF, 1, 0, 32'h34, 0, 4'hF, 1, 0, 32'hA500_0024);
        applyStimulus(1, 0, 32'h28, 0, 4'hF, 1, 0, 32'h34, 0, 4'hF, 0, 1, 32'hA500_0034);
        idle(4);

        // Full and partial writes, read back by the other and same master
        applyStimulus(1, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 4'hF, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 4'hF, 1, 0, 32'h10, 0, 4'hF, 0, 1, 32'hDEAD_BEEF);
        applyStimulus(1, 1, 32'h14, 32'h1122_3344, 4'b0101, 0, 0, 0, 0, 4'hF, 1, 0, 0);
        applyStimulus(1, 0, 32'h14, 0, 4'hF, 0, 0, 0, 0, 4'hF, 1, 0, 32'hA522_0044);
        idle(4);

        // Isolated master 1 read: exact-latency return on both instances
        applyStimulus(0, 0, 0, 0, 4'hF, 1, 0, 32'h08, 0, 4'hF, 0, 1, 32'hA500_0008);
        idle(5);

        // Two reads in flight, then reset discards them
        applyStimulus(0, 0, 0, 0, 4'hF, 1, 0, 32'h04, 0, 4'hF, 0, 1, 32'hA500_0004);
        applyStimulus(1, 0, 32'h00, 0, 4'hF, 0, 0, 0, 0, 4'hF, 1, 0, 32'hA500_0000);
        assertReset();
        applyStimulus(1, 0, 32'h0C, 0, 4'hF, 1, 0, 32'h18, 0, 4'hF, 0, 0, 0);
        applyStimulus(1, 0, 32'h0C, 0, 4'hF, 1, 0, 32'h18, 0, 4'hF, 0, 0, 0);
        rst = 1'b1;
        applyStimulus(1, 0, 32'h0C, 0, 4'hF, 1, 0, 32'h18, 0, 4'hF, 1, 0, 32'hA500_000C);
        applyStimulus(0, 0, 0, 0, 4'hF, 1, 0, 32'h18, 0, 4'hF, 0, 1, 32'hA500_0018);
        idle(6);

        // Master 0 toggles req while master 1 requests steadily
        applyStimulus(1, 0, 32'h20, 0, 4'hF, 1, 0, 32'h1C, 0, 4'hF, 1, 0, 32'hA500_0020);
        applyStimulus(0, 0, 0, 0, 4'hF, 1, 0, 32'h1C, 0, 4'hF, 0, 1, 32'hA500_001C);
        applyStimulus(1, 0, 32'h24, 0, 4'hF, 1, 0, 32'h38, 0, 4'hF, 1, 0, 32'hA500_0024);
        applyStimulus(0, 0, 0, 0, 4'hF, 1, 0, 32'h38, 0, 4'hF, 0, 1, 32'hA500_0038);
        idle(6);

        chk_gnt = 1'b0;
        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
